// File: rtl/my_fifo_rd_stream.sv
// my_fifo_rd_stream: turns the standard-mode read port of a synchronous FIFO18E1 wrapper into a
// valid/ready stream. Defining MY_FIFO_RD_STREAM_STATS_EN adds a handshake counter (word_count).
module my_fifo_rd_stream #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RST_HOLD = 5
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic             fifo_rderr,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
`ifdef MY_FIFO_RD_STREAM_STATS_EN
  output logic [31:0]      word_count,
`endif
  output logic             rd_err
);

  localparam int unsigned DEPTH = RD_LAT + 2;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned OW    = CW + 1;
  localparam int unsigned HW    = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  logic [HW-1:0]     r_hold;
  logic [RD_LAT-1:0] r_pipe;
  logic [WIDTH-1:0]  r_buf [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_rd_err;

  logic [CW-1:0]     w_inflight;
  logic [OW-1:0]     w_occ;
  logic [RD_LAT-1:0] w_pipe_d;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_pipe[i]);
    end
  end

  // Occupancy counts words already buffered plus words still travelling through the FIFO
  // output pipeline, so a read is only issued when a slot is guaranteed on arrival.
  assign w_occ      = OW'(r_count) + OW'(w_inflight);
  assign w_issue    = !fifo_empty && !flush && (r_hold == '0) && (w_occ < OW'(DEPTH));
  assign fifo_rd_en = w_issue;

  assign w_push  = r_pipe[RD_LAT-1] && !flush;
  assign m_valid = (r_count != '0) && !flush;
  assign w_pop   = m_valid && m_ready;
  assign m_data  = (r_count != '0) ? r_buf[r_rd_ptr] : '0;
  assign rd_err  = r_rd_err;

  if (RD_LAT == 1) begin : g_pipe_one
    assign w_pipe_d = w_issue;
  end else begin : g_pipe_multi
    assign w_pipe_d = {r_pipe[RD_LAT-2:0], w_issue};
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      r_hold   <= HW'(RST_HOLD);
      r_pipe   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rd_err <= 1'b0;
    end else begin
      if (r_hold != '0) begin
        r_hold <= r_hold - HW'(1);
      end
      if (fifo_rderr) begin
        r_rd_err <= 1'b1;
      end
      if (flush) begin
        r_pipe   <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_pipe <= w_pipe_d;
        if (w_push) begin
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_push) begin
      r_buf[r_wr_ptr] <= fifo_dout;
    end
  end

  // A push into a full buffer without a same-cycle pop means the issue rule was violated.
  assert property (@(posedge rd_clk) disable iff (rst)
                   !(w_push && !w_pop && (r_count == CW'(DEPTH))));

`ifdef MY_FIFO_RD_STREAM_STATS_EN
  logic [31:0] r_word_count;

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (w_pop) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

  assign word_count = r_word_count;
`endif

endmodule
